// File: rtl/store_align_buffer_pkg.sv
// ---------------------------------------------------------------------------
// store_pkg: shared definitions for the store alignment buffer.
//   F3_SB / F3_SH / F3_SW : store width codes carried in funct3.
//   st_entry_t            : one queued write (word address, steered data, byte
//                           enables). The address field is 32 bits wide, so
//                           the buffer supports byte address widths up to 32.
// ---------------------------------------------------------------------------
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_entry_t;

endpackage

// File: rtl/store_align_buffer_if.sv
// ---------------------------------------------------------------------------
// store_align_buffer_if: request side (memory stage) and drain side (data
// memory) of the store alignment buffer, plus its status flags.
//   slave  : the view used by store_align_buffer.
//   master : the view used by whoever drives requests / acts as memory.
// ---------------------------------------------------------------------------
interface store_align_buffer_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic [2:0]    req_funct3;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          store_misaligned;
  logic          store_illegal;
  logic          buf_empty;

  modport slave (
    input  req_valid, req_addr, req_data, req_funct3, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
           store_misaligned, store_illegal, buf_empty
  );

  modport master (
    output req_valid, req_addr, req_data, req_funct3, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
           store_misaligned, store_illegal, buf_empty
  );
endinterface

// File: rtl/store_align_buffer_lane_steer.sv
// ---------------------------------------------------------------------------
// store_lane_steer: combinational byte-lane steering for SB/SH/SW.
//   funct3     in  : store width code
//   addr_lo    in  : byte offset within the word
//   data       in  : unaligned rs2 data
//   wdata      out : data replicated onto every lane it may land in
//   be         out : byte enables, bit i covers wdata[8i+7:8i]
//   misaligned out : legal width but offset not naturally aligned
//   illegal    out : funct3 is not a store width (wins over misaligned)
// ---------------------------------------------------------------------------
module store_lane_steer
  import store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned,
  output logic        illegal
);

  always_comb begin
    wdata      = '0;
    be         = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_SB: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      F3_SH: begin
        wdata      = {2{data[15:0]}};
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      F3_SW: begin
        wdata      = data;
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_align_buffer.sv
// ---------------------------------------------------------------------------
// store_align_buffer: steers SB/SH/SW stores onto byte lanes, queues aligned
// writes in a DEPTH-entry FIFO and drains them over a valid/ready handshake.
// Misaligned / illegal stores are consumed and reported by a one-cycle flag.
//   clk, reset : clock, synchronous active-high reset
//   bus        : store_align_buffer_if.slave (request, drain, status flags)
// Optional build macro STORE_BUF_BYPASS_EN: when the FIFO is empty and the
// memory is ready, an aligned request is forwarded to the memory port in the
// same cycle without being queued. Without it, every write spends at least
// one cycle in the FIFO and req_* has no combinational path to mem_*.
// ---------------------------------------------------------------------------
module store_align_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 2,   // power of two, >= 2
  parameter int AW    = 32   // <= 32
) (
  input logic               clk,
  input logic               reset,
  store_align_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  st_entry_t       fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            misaligned_reg, illegal_reg;

  logic [31:0]     st_wdata;
  logic [3:0]      st_be;
  logic            st_misaligned, st_illegal;
  logic            full, empty, accept, aligned_ok, bypass, enq, deq;
  st_entry_t       new_entry, head;

  store_lane_steer u_steer (
    .funct3     (bus.req_funct3),
    .addr_lo    (bus.req_addr[1:0]),
    .data       (bus.req_data),
    .wdata      (st_wdata),
    .be         (st_be),
    .misaligned (st_misaligned),
    .illegal    (st_illegal)
  );

  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign accept     = bus.req_valid && !full;
  assign aligned_ok = !st_misaligned && !st_illegal;

`ifdef STORE_BUF_BYPASS_EN
  assign bypass = accept && aligned_ok && empty && bus.mem_ready;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed write never occupies a slot; dequeue only ever pops real entries.
  assign enq = accept && aligned_ok && !bypass;
  assign deq = !empty && bus.mem_ready;

  always_comb begin
    new_entry       = '0;
    new_entry.addr  = 32'({bus.req_addr[AW-1:2], 2'b00});
    new_entry.wdata = st_wdata;
    new_entry.be    = st_be;
  end

  // Storage carries no reset: emptiness is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr_reg] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      misaligned_reg <= 1'b0;
      illegal_reg    <= 1'b0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg      <= count_reg + CW'(enq) - CW'(deq);
      illegal_reg    <= accept && st_illegal;
      misaligned_reg <= accept && st_misaligned && !st_illegal;
    end
  end

  assign head = fifo_mem[rd_ptr_reg];

  // Outputs read zero while nothing is pending, so a fresh reset shows zeros.
  always_comb begin
    bus.mem_valid = !empty;
    bus.mem_addr  = empty ? '0 : head.addr[AW-1:0];
    bus.mem_wdata = empty ? '0 : head.wdata;
    bus.mem_be    = empty ? '0 : head.be;
    if (bypass) begin
      bus.mem_valid = 1'b1;
      bus.mem_addr  = new_entry.addr[AW-1:0];
      bus.mem_wdata = new_entry.wdata;
      bus.mem_be    = new_entry.be;
    end
  end

  assign bus.req_ready        = !full;
  assign bus.buf_empty        = empty;
  assign bus.store_misaligned = misaligned_reg;
  assign bus.store_illegal    = illegal_reg;

endmodule

// File: tb/tb_store_align_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_align_buffer: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the store buffer.
// ---------------------------------------------------------------------------
module tb_store_align_buffer;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  b;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  exp_t q[$];
  logic known   = 1'b0;
  logic exp_mis = 1'b0;
  logic exp_ill = 1'b0;

  always #5 clk = ~clk;

  store_align_buffer_if #(.AW(32)) bus ();

  store_align_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference classification straight from the store width rules.
  task automatic classify(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                          output logic ill, output logic mis, output exp_t e);
    int off;
    off = a % 4;
    ill = 1'b0;
    mis = 1'b0;
    e.a = a - off;
    e.w = 0;
    e.b = 0;
    if (f == 3'd0) begin
      e.w = (d % 256) * 32'h0101_0101;
      e.b = 4'(1 << off);
    end else if (f == 3'd1) begin
      e.w = (d % 65536) * 32'h0001_0001;
      e.b = (off >= 2) ? 4'b1100 : 4'b0011;
      mis = (off % 2) != 0;
    end else if (f == 3'd2) begin
      e.w = d;
      e.b = 4'b1111;
      mis = off != 0;
    end else begin
      ill = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check_eq("req_ready", bus.req_ready, q.size() < DEPTH);
    check_eq("buf_empty", bus.buf_empty, q.size() == 0);
    check_eq("mem_valid", bus.mem_valid, q.size() != 0);
    check_eq("mem_addr", bus.mem_addr, (q.size() != 0) ? q[0].a : 32'h0);
    check_eq("mem_wdata", bus.mem_wdata, (q.size() != 0) ? q[0].w : 32'h0);
    check_eq("mem_be", bus.mem_be, (q.size() != 0) ? q[0].b : 4'h0);
    check_eq("store_misaligned", bus.store_misaligned, exp_mis);
    check_eq("store_illegal", bus.store_illegal, exp_ill);
  endtask

  task automatic model_update();
    logic acc, ill, mis;
    exp_t e;
    if (reset) begin
      q.delete();
      exp_mis = 1'b0;
      exp_ill = 1'b0;
      known   = 1'b1;
      return;
    end
    acc = bus.req_valid && (q.size() < DEPTH);
    if (q.size() != 0 && bus.mem_ready) void'(q.pop_front());
    classify(bus.req_funct3, bus.req_addr, bus.req_data, ill, mis, e);
    exp_ill = acc && ill;
    exp_mis = acc && mis && !ill;
    if (acc) begin
      $display("txn f3=%0d addr=%08h data=%08h -> %s", bus.req_funct3, bus.req_addr,
               bus.req_data, ill ? "illegal" : (mis ? "misaligned" : "queued"));
      if (!ill && !mis) q.push_back(e);
    end
  endtask

  // One clock: drive inputs, check/advance the model mid-cycle, stop #1 after the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f, input logic r, input logic rs);
    bus.req_valid  = v;
    bus.req_addr   = a;
    bus.req_data   = d;
    bus.req_funct3 = f;
    bus.mem_ready  = r;
    reset          = rs;
    @(negedge clk);
    if (known) check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    step(1'b0, 32'h0, 32'h0, 3'd0, r, 1'b0);
  endtask

  initial begin
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);
    check_eq("rst_buf_empty", bus.buf_empty, 1'b1);
    check_eq("rst_mem_valid", bus.mem_valid, 1'b0);

    // SB to the top byte lane
    step(1'b1, 32'h1003, 32'hDEADBEEF, 3'd0, 1'b1, 1'b0);
    check_eq("sb_valid", bus.mem_valid, 1'b1);
    check_eq("sb_addr", bus.mem_addr, 32'h1000);
    check_eq("sb_be", bus.mem_be, 4'b1000);
    check_eq("sb_wdata", bus.mem_wdata, 32'hEFEFEFEF);
    idle(1'b1);
    check_eq("sb_drained", bus.buf_empty, 1'b1);

    // SH aligned then misaligned
    step(1'b1, 32'h2002, 32'h0000CAFE, 3'd1, 1'b1, 1'b0);
    check_eq("sh_be", bus.mem_be, 4'b1100);
    check_eq("sh_wdata", bus.mem_wdata, 32'hCAFECAFE);
    idle(1'b1);
    step(1'b1, 32'h2001, 32'h0000CAFE, 3'd1, 1'b1, 1'b0);
    check_eq("sh_mis_pulse", bus.store_misaligned, 1'b1);
    check_eq("sh_mis_novalid", bus.mem_valid, 1'b0);
    idle(1'b1);
    check_eq("sh_mis_clear", bus.store_misaligned, 1'b0);

    // illegal funct3, then legal SW
    step(1'b1, 32'h3000, 32'h12345678, 3'd3, 1'b1, 1'b0);
    check_eq("ill_pulse", bus.store_illegal, 1'b1);
    check_eq("ill_empty", bus.buf_empty, 1'b1);
    step(1'b1, 32'h3000, 32'h12345678, 3'd2, 1'b1, 1'b0);
    check_eq("ill_clear", bus.store_illegal, 1'b0);
    check_eq("sw_be", bus.mem_be, 4'b1111);
    check_eq("sw_wdata", bus.mem_wdata, 32'h12345678);
    idle(1'b1);

    // backpressure: three back-to-back SW into a 2-deep buffer
    step(1'b1, 32'h4000, 32'hA0A0A0A0, 3'd2, 1'b0, 1'b0);
    step(1'b1, 32'h4004, 32'hB1B1B1B1, 3'd2, 1'b0, 1'b0);
    check_eq("full_ready", bus.req_ready, 1'b0);
    step(1'b1, 32'h4008, 32'hC2C2C2C2, 3'd2, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("hold_addr", bus.mem_addr, 32'h4000);
    check_eq("hold_wdata", bus.mem_wdata, 32'hA0A0A0A0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check_eq("drain_ready", bus.req_ready, 1'b1);

    // steady one-entry occupancy with simultaneous enqueue and dequeue
    step(1'b1, 32'h5000, 32'h50505050, 3'd2, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 32'h5000 + 4 * i, 32'h50505050 + i, 3'd2, 1'b1, 1'b0);
      check_eq("flow_nonempty", bus.buf_empty, 1'b0);
      check_eq("flow_ready", bus.req_ready, 1'b1);
    end
    idle(1'b1);
    idle(1'b1);

    // reset with two entries pending
    step(1'b1, 32'h6000, 32'h66666666, 3'd2, 1'b0, 1'b0);
    step(1'b1, 32'h6004, 32'h77777777, 3'd2, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);
    check_eq("rst_mid_valid", bus.mem_valid, 1'b0);
    check_eq("rst_mid_empty", bus.buf_empty, 1'b1);
    check_eq("rst_mid_ready", bus.req_ready, 1'b1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d;
      logic [2:0]  f;
      a = 32'h8000 + $urandom_range(0, 63);
      d = $urandom;
      f = 3'($urandom_range(0, 4));
      step(1'($urandom_range(0, 1)), a, d, f, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 60) == 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
